multi_port_mem: RTL and testbench

MULTI_PORT_MEM -- requirements
Module: multi_port_mem

---
 rtl/mem_pkg.sv | 22 ++
 rtl/mem_chan_pipe.sv | 85 ++++++++
 rtl/multi_port_mem.sv | 82 ++++++++
 tb/tb_multi_port_mem.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared bus command encoding and default sizing for multi_port_mem.
// Optional range checking is enabled with MEM_RANGE_CHK_EN.
package mem_pkg;

    typedef enum logic [1:0] {
        BUS_NONE  = 2'd0,
        BUS_LOAD  = 2'd1,
        BUS_STORE = 2'd2
    } bus_cmd_e;

    localparam int NCH_DEF     = 2;
    localparam int DATA_W_DEF  = 32;
    localparam int ADDR_W_DEF  = 32;
    localparam int DEPTH_DEF   = 8192;
    localparam int LATENCY_DEF = 4;
    localparam int NTAGS_DEF   = 7;

    function automatic int tag_width(input int ntags);
        return $clog2(ntags + 1);
    endfunction

endpackage

// File: rtl/mem_chan_pipe.sv
// Per-channel tag allocator and fixed-latency completion delay line.
// MEM_RANGE_CHK_EN adds an error bit that travels with each request.
module mem_chan_pipe
    import mem_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int LATENCY = LATENCY_DEF,
    parameter int NTAGS   = NTAGS_DEF,
    parameter int TAG_W   = tag_width(NTAGS_DEF)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_vld,
    input  logic [DATA_W-1:0] ld_data,
`ifdef MEM_RANGE_CHK_EN
    input  logic              ld_err,
    output logic              cpl_err,
`endif
    output logic [TAG_W-1:0]  resp_tag,
    output logic [TAG_W-1:0]  cpl_tag,
    output logic [DATA_W-1:0] cpl_data
);

    logic [NTAGS:1]                  busy;
    logic [NTAGS:1]                  busy_n;
    logic [TAG_W-1:0]                free_tag;
    logic [LATENCY-1:0][TAG_W-1:0]   tag_q;
    logic [LATENCY-1:0][DATA_W-1:0]  data_q;
`ifdef MEM_RANGE_CHK_EN
    logic [LATENCY-1:0]              err_q;
`endif

    always_comb begin
        free_tag = '0;
        for (int i = NTAGS; i >= 1; i--) begin
            if (!busy[i]) free_tag = TAG_W'(i);
        end
    end

    assign resp_tag = (rst && req_vld) ? free_tag : '0;
    assign cpl_tag  = tag_q[LATENCY-1];
    assign cpl_data = data_q[LATENCY-1];
`ifdef MEM_RANGE_CHK_EN
    assign cpl_err  = err_q[LATENCY-1];
`endif

    // A tag stays busy through its completion cycle and frees on that edge.
    always_comb begin
        busy_n = busy;
        for (int i = 1; i <= NTAGS; i++) begin
            if (cpl_tag == TAG_W'(i)) busy_n[i] = 1'b0;
            if (resp_tag == TAG_W'(i)) busy_n[i] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy   <= '0;
            tag_q  <= '0;
            data_q <= '0;
        end else begin
            busy      <= busy_n;
            tag_q[0]  <= resp_tag;
            data_q[0] <= (resp_tag != '0) ? ld_data : '0;
            for (int i = 1; i < LATENCY; i++) begin
                tag_q[i]  <= tag_q[i-1];
                data_q[i] <= data_q[i-1];
            end
        end
    end

`ifdef MEM_RANGE_CHK_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_q <= '0;
        end else begin
            err_q[0] <= (resp_tag != '0) && ld_err;
            for (int i = 1; i < LATENCY; i++) begin
                err_q[i] <= err_q[i-1];
            end
        end
    end
`endif

endmodule

// File: rtl/multi_port_mem.sv
// Multi-channel tagged memory with fixed completion latency per request.
// Define MEM_RANGE_CHK_EN for out-of-range detection via cpl_err.
module multi_port_mem
    import mem_pkg::*;
#(
    parameter int NCH     = NCH_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DEPTH   = DEPTH_DEF,
    parameter int LATENCY = LATENCY_DEF,
    parameter int NTAGS   = NTAGS_DEF,
    localparam int TAG_W  = $clog2(NTAGS + 1)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NCH-1:0][1:0]          req_cmd,
    input  logic [NCH-1:0][ADDR_W-1:0]   req_addr,
    input  logic [NCH-1:0][DATA_W-1:0]   req_data,
    output logic [NCH-1:0][TAG_W-1:0]    resp_tag,
    output logic [NCH-1:0][TAG_W-1:0]    cpl_tag,
`ifdef MEM_RANGE_CHK_EN
    output logic [NCH-1:0]               cpl_err,
`endif
    output logic [NCH-1:0][DATA_W-1:0]   cpl_data
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0]              mem [DEPTH];
    logic [NCH-1:0][IDX_W-1:0]      idx;
    logic [NCH-1:0]                 is_st;
    logic [NCH-1:0]                 vld;
    logic [NCH-1:0]                 we;
    logic [NCH-1:0]                 in_range;
    logic [NCH-1:0][DATA_W-1:0]     ld_data;

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        logic [ADDR_W-3:0] waddr;

        assign waddr = req_addr[c][ADDR_W-1:2];
        assign idx[c] = IDX_W'(waddr % (ADDR_W-2)'(DEPTH));
`ifdef MEM_RANGE_CHK_EN
        assign in_range[c] = waddr < (ADDR_W-2)'(DEPTH);
`else
        assign in_range[c] = 1'b1;
`endif
        assign vld[c]   = req_cmd[c] != BUS_NONE;
        assign is_st[c] = req_cmd[c] == BUS_STORE;
        assign we[c]    = is_st[c] && in_range[c]
                          && (resp_tag[c] != '0);
        // Combinational read sees the array before this edge's stores.
        assign ld_data[c] = (is_st[c] || !in_range[c])
                            ? '0 : mem[idx[c]];

        mem_chan_pipe #(
            .DATA_W  (DATA_W),
            .LATENCY (LATENCY),
            .NTAGS   (NTAGS),
            .TAG_W   (TAG_W)
        ) u_pipe (
            .clk      (clk),
            .rst      (rst),
            .req_vld  (vld[c]),
            .ld_data  (ld_data[c]),
`ifdef MEM_RANGE_CHK_EN
            .ld_err   (!in_range[c]),
            .cpl_err  (cpl_err[c]),
`endif
            .resp_tag (resp_tag[c]),
            .cpl_tag  (cpl_tag[c]),
            .cpl_data (cpl_data[c])
        );
    end

    // Lowest channel is applied last so it wins same-word collisions.
    always_ff @(posedge clk) begin
        for (int c = NCH - 1; c >= 0; c--) begin
            if (we[c]) mem[idx[c]] <= req_data[c];
        end
    end

endmodule

// File: tb/tb_multi_port_mem.sv
// Directed checks for multi_port_mem; second instance uses a long latency.
module tb_multi_port_mem;
    import mem_pkg::*;

    logic clk = 1'b0;
    logic rst;

    logic [1:0][1:0]  req_cmd;
    logic [1:0][31:0] req_addr;
    logic [1:0][31:0] req_data;
    logic [1:0][2:0]  resp_tag;
    logic [1:0][2:0]  cpl_tag;
    logic [1:0][31:0] cpl_data;

    logic [1:0][1:0]  req_cmd_l;
    logic [1:0][31:0] req_addr_l;
    logic [1:0][31:0] req_data_l;
    logic [1:0][2:0]  resp_tag_l;
    logic [1:0][2:0]  cpl_tag_l;
    logic [1:0][31:0] cpl_data_l;
`ifdef MEM_RANGE_CHK_EN
    logic [1:0]       cpl_err;
    logic [1:0]       cpl_err_l;
`endif

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    multi_port_mem dut (
        .clk      (clk),
        .rst      (rst),
        .req_cmd  (req_cmd),
        .req_addr (req_addr),
        .req_data (req_data),
        .resp_tag (resp_tag),
        .cpl_tag  (cpl_tag),
`ifdef MEM_RANGE_CHK_EN
        .cpl_err  (cpl_err),
`endif
        .cpl_data (cpl_data)
    );

    multi_port_mem #(.LATENCY(12)) dut_l (
        .clk      (clk),
        .rst      (rst),
        .req_cmd  (req_cmd_l),
        .req_addr (req_addr_l),
        .req_data (req_data_l),
        .resp_tag (resp_tag_l),
        .cpl_tag  (cpl_tag_l),
`ifdef MEM_RANGE_CHK_EN
        .cpl_err  (cpl_err_l),
`endif
        .cpl_data (cpl_data_l)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            req_cmd = '0;
            req_cmd_l = '0;
        end
    endtask

    task automatic test_reset();
        req_cmd = {BUS_LOAD, BUS_LOAD};
        req_addr = '0;
        req_data = '0;
        #3;
        checks++;
        if (resp_tag !== '0) $display("FAIL rst_resp: got %h want 0", resp_tag);
        else passed++;
        tick();
        @(negedge clk);
        checks++;
        if (cpl_tag !== '0 || resp_tag !== '0)
            $display("FAIL rst_tags: got %h/%h want 0", cpl_tag, resp_tag);
        else passed++;
        checks++;
        if (cpl_data !== '0) $display("FAIL rst_data: got %h want 0", cpl_data);
        else passed++;
        tick();
        req_cmd = '0;
        rst = 1'b1;
        idle(2);
    endtask

    task automatic test_load_latency();
        tick();
        req_cmd[0] = BUS_LOAD;
        req_addr[0] = 32'h14;
        @(negedge clk);
        checks++;
        if (resp_tag[0] !== 3'd1) $display("FAIL lat_resp: got %0d want 1", resp_tag[0]);
        else passed++;
        checks++;
        if (resp_tag[1] !== 3'd0) $display("FAIL lat_resp_ch1: got %0d want 0", resp_tag[1]);
        else passed++;
        for (int k = 1; k <= 4; k++) begin
            tick();
            req_cmd = '0;
            @(negedge clk);
            checks++;
            if (k < 4) begin
                if (cpl_tag[0] !== 3'd0)
                    $display("FAIL lat_early%0d: got %0d want 0", k, cpl_tag[0]);
                else passed++;
            end else begin
                if (cpl_tag[0] !== 3'd1 || cpl_data[0] !== 32'hDEADBEEF)
                    $display("FAIL lat_cpl: got %0d/%h want 1/deadbeef",
                             cpl_tag[0], cpl_data[0]);
                else passed++;
            end
        end
        tick();
        @(negedge clk);
        checks++;
        if (cpl_tag[0] !== 3'd0) $display("FAIL lat_after: got %0d want 0", cpl_tag[0]);
        else passed++;
        idle(2);
    endtask

    task automatic test_tag_exhaust();
        for (int k = 0; k < 8; k++) begin
            tick();
            req_cmd_l[1] = BUS_LOAD;
            req_addr_l[1] = 32'h14;
            @(negedge clk);
            checks++;
            if (resp_tag_l[1] !== ((k < 7) ? 3'(k + 1) : 3'd0))
                $display("FAIL tag_alloc%0d: got %0d want %0d", k, resp_tag_l[1],
                         (k < 7) ? k + 1 : 0);
            else passed++;
        end
        idle(4);
        @(negedge clk);
        checks++;
        if (cpl_tag_l[1] !== 3'd0) $display("FAIL tag_early: got %0d want 0", cpl_tag_l[1]);
        else passed++;
        tick();
        req_cmd_l[1] = BUS_LOAD;
        @(negedge clk);
        checks++;
        if (cpl_tag_l[1] !== 3'd1 || cpl_data_l[1] !== 32'hDEADBEEF)
            $display("FAIL tag_cpl1: got %0d/%h want 1/deadbeef", cpl_tag_l[1], cpl_data_l[1]);
        else passed++;
        checks++;
        if (resp_tag_l[1] !== 3'd0) $display("FAIL tag_busy_in_cpl: got %0d want 0", resp_tag_l[1]);
        else passed++;
        tick();
        @(negedge clk);
        checks++;
        if (resp_tag_l[1] !== 3'd1) $display("FAIL tag_reuse: got %0d want 1", resp_tag_l[1]);
        else passed++;
        checks++;
        if (cpl_tag_l[1] !== 3'd2) $display("FAIL tag_cpl2: got %0d want 2", cpl_tag_l[1]);
        else passed++;
        idle(1);
    endtask

    task automatic test_store_priority();
        tick();
        req_cmd = {BUS_STORE, BUS_STORE};
        req_addr = {32'h40, 32'h40};
        req_data = {32'h22, 32'h11};
        @(negedge clk);
        checks++;
        if (resp_tag !== {3'd1, 3'd1}) $display("FAIL st_resp: got %h want 1/1", resp_tag);
        else passed++;
        idle(4);
        @(negedge clk);
        checks++;
        if (cpl_tag !== {3'd1, 3'd1} || cpl_data !== '0)
            $display("FAIL st_cpl: got %h/%h want 1/1 data 0", cpl_tag, cpl_data);
        else passed++;
        tick();
        req_cmd[0] = BUS_LOAD;
        @(negedge clk);
        checks++;
        if (resp_tag[0] !== 3'd1) $display("FAIL st_rd_resp: got %0d want 1", resp_tag[0]);
        else passed++;
        idle(4);
        @(negedge clk);
        checks++;
        if (cpl_tag[0] !== 3'd1 || cpl_data[0] !== 32'h11)
            $display("FAIL st_prio: got %0d/%h want 1/11", cpl_tag[0], cpl_data[0]);
        else passed++;
        idle(1);
    endtask

    task automatic test_back_to_back();
        tick();
        req_cmd = {BUS_STORE, BUS_LOAD};
        req_addr = {32'h40, 32'h40};
        req_data = {32'h33, 32'h0};
        @(negedge clk);
        checks++;
        if (resp_tag !== {3'd1, 3'd1}) $display("FAIL b2b_resp0: got %h want 1/1", resp_tag);
        else passed++;
        tick();
        req_cmd = {BUS_NONE, BUS_LOAD};
        @(negedge clk);
        checks++;
        if (resp_tag[0] !== 3'd2) $display("FAIL b2b_resp1: got %0d want 2", resp_tag[0]);
        else passed++;
        idle(3);
        @(negedge clk);
        checks++;
        if (cpl_tag[0] !== 3'd1 || cpl_data[0] !== 32'h11)
            $display("FAIL b2b_pre: got %0d/%h want 1/11", cpl_tag[0], cpl_data[0]);
        else passed++;
        checks++;
        if (cpl_tag[1] !== 3'd1 || cpl_data[1] !== 32'h0)
            $display("FAIL b2b_st_cpl: got %0d/%h want 1/0", cpl_tag[1], cpl_data[1]);
        else passed++;
        idle(1);
        @(negedge clk);
        checks++;
        if (cpl_tag[0] !== 3'd2 || cpl_data[0] !== 32'h33)
            $display("FAIL b2b_post: got %0d/%h want 2/33", cpl_tag[0], cpl_data[0]);
        else passed++;
        idle(1);
    endtask

    task automatic test_reset_mid();
        for (int k = 0; k < 3; k++) begin
            tick();
            req_cmd[0] = BUS_LOAD;
            req_addr[0] = 32'h14;
            @(negedge clk);
            checks++;
            if (resp_tag[0] !== 3'(k + 1))
                $display("FAIL mid_resp%0d: got %0d want %0d", k, resp_tag[0], k + 1);
            else passed++;
        end
        tick();
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (resp_tag[0] !== 3'd0 || cpl_tag[0] !== 3'd0)
            $display("FAIL mid_in_rst: got %0d/%0d want 0/0", resp_tag[0], cpl_tag[0]);
        else passed++;
        tick();
        rst = 1'b1;
        req_cmd = '0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            checks++;
            if (cpl_tag[0] !== 3'd0)
                $display("FAIL mid_flush%0d: got %0d want 0", k, cpl_tag[0]);
            else passed++;
            tick();
        end
        req_cmd[0] = BUS_LOAD;
        req_addr[0] = 32'h40;
        @(negedge clk);
        checks++;
        if (resp_tag[0] !== 3'd1) $display("FAIL mid_retag: got %0d want 1", resp_tag[0]);
        else passed++;
        idle(4);
        @(negedge clk);
        checks++;
        if (cpl_tag[0] !== 3'd1 || cpl_data[0] !== 32'h33)
            $display("FAIL mid_kept: got %0d/%h want 1/33", cpl_tag[0], cpl_data[0]);
        else passed++;
        idle(1);
    endtask

    task automatic test_wrap();
        tick();
        req_cmd[1] = BUS_LOAD;
        req_addr[1] = 32'h8000;
        @(negedge clk);
        checks++;
        if (resp_tag[1] !== 3'd1) $display("FAIL wrap_resp: got %0d want 1", resp_tag[1]);
        else passed++;
        idle(4);
        @(negedge clk);
        checks++;
`ifdef MEM_RANGE_CHK_EN
        if (cpl_tag[1] !== 3'd1 || cpl_data[1] !== 32'h0 || cpl_err[1] !== 1'b1)
            $display("FAIL wrap_err: got %0d/%h/%b want 1/0/1",
                     cpl_tag[1], cpl_data[1], cpl_err[1]);
        else passed++;
`else
        if (cpl_tag[1] !== 3'd1 || cpl_data[1] !== 32'hA5A50000)
            $display("FAIL wrap_data: got %0d/%h want 1/a5a50000", cpl_tag[1], cpl_data[1]);
        else passed++;
`endif
        idle(1);
    endtask

    initial begin
        rst = 1'b0;
        req_cmd_l = '0;
        req_addr_l = '0;
        req_data_l = '0;
        dut.mem[5] = 32'hDEADBEEF;
        dut.mem[0] = 32'hA5A50000;
        dut_l.mem[5] = 32'hDEADBEEF;
        test_reset();
        test_load_latency();
        test_tag_exhaust();
        test_store_priority();
        test_back_to_back();
        test_reset_mid();
        test_wrap();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "timeout");
    end

endmodule
